acc_sequencer: RTL

Instruction sequencer and accumulator stage that sits directly upstream of the 8-bit ALU. It fetches 12-bit instruction words from a synchronous program ROM, decodes them, and drives the ALU opcode and `b` operand. It holds the accumulator that feeds the ALU `a` input and writes back the ALU's 9-bit result as accumulator, carry and zero flags. It also executes the control-flow opcodes the ALU does not implement: JMP, JZ, JC and HALT.

---
 rtl/acc_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/acc_sequencer.sv
// Instruction sequencer and accumulator in front of the 8-bit ALU: fetch/decode/exec
// of 12-bit words from a synchronous ROM, with JMP/JZ/JC/HALT handled locally.
module acc_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    input  logic [11:0]     rom_data,
    output logic [3:0]      alu_inst,
    output logic [7:0]      alu_b,
    input  logic [8:0]      alu_ans,
    output logic [7:0]      acc,
    output logic            carry,
    output logic            zero,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_t;

    localparam logic [3:0] OP_NOP  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx, pc_inc, imm_pc;
    logic [11:0]     ir;
    logic [3:0]      op;
    logic            wb_acc, wb_carry;

    assign op     = ir[11:8];
    assign pc_inc = pc + PC_W'(1);
    assign imm_pc = PC_W'(ir[7:0]);
    assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_inc;
        wb_acc   = 1'b0;
        wb_carry = 1'b0;
        case (state)
            S_IDLE:   if (run) state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (op == OP_HALT) ? S_HALTED : S_FETCH;
            default:  state_nx = state;
        endcase
        // Branch conditions use the flags as they stand entering EXEC.
        case (op)
            OP_JMP:  pc_nx = imm_pc;
            OP_JZ:   pc_nx = zero  ? imm_pc : pc_inc;
            OP_JC:   pc_nx = carry ? imm_pc : pc_inc;
            OP_HALT: pc_nx = pc;
            default: pc_nx = pc_inc;
        endcase
        wb_acc   = (op <= 4'hB) && (op != OP_NOP);
        wb_carry = (op == 4'h2) || (op == 4'h3) || (op == 4'h5) || (op == 4'h6);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            rom_addr <= '0;
            ir       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            alu_inst <= OP_NOP;
            alu_b    <= '0;
        end else begin
            alu_inst <= OP_NOP;
            alu_b    <= '0;
            case (state)
                // rom_addr is presented during FETCH so the word lands in DECODE.
                S_IDLE: if (run) rom_addr <= pc;
                S_DECODE: begin
                    ir <= rom_data;
                    if (rom_data[11:8] <= 4'hB) begin
                        alu_inst <= rom_data[11:8];
                        alu_b    <= rom_data[7:0];
                    end
                end
                S_EXEC: begin
                    pc <= pc_nx;
                    if (op != OP_HALT) rom_addr <= pc_nx;
                    if (wb_acc) begin
                        acc  <= alu_ans[7:0];
                        zero <= (alu_ans[7:0] == 8'h00);
                    end
                    if (wb_carry) carry <= alu_ans[8];
                end
                default: ;
            endcase
        end
    end

endmodule
